ceespu_writeback: RTL

Execute-to-writeback stage directly downstream of `ceespu_alu`. It consumes the ALU result, carry-out and multi-cycle handshake, and registers the result into a register-file write port. It holds the architectural carry flag that feeds back into the ALU's `I_Cin`, and raises a pipeline stall for as long as a multi-cycle ALU operation is outstanding. A watchdog aborts multi-cycle operations that never complete.

---
 rtl/ceespu_writeback.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ceespu_writeback.sv
// Execute-to-writeback stage behind ceespu_alu: registers ALU results into the
// register-file write port, owns the carry flag and stalls issue during multi-cycle ops.
module ceespu_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_TIMEOUT     = 64
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_valid,
    input  logic [REG_ADDR_WIDTH-1:0] I_rd,
    input  logic                      I_wbEnable,
    input  logic                      I_setCarry,
    input  logic                      I_multiCycle,
    input  logic [DATA_WIDTH-1:0]     I_dataResult,
    input  logic                      I_Cout,
    input  logic                      I_dataReady,
    output logic                      O_stall,
    output logic                      O_carry,
    output logic                      O_regWe,
    output logic [REG_ADDR_WIDTH-1:0] O_regAddr,
    output logic [DATA_WIDTH-1:0]     O_regData,
    output logic                      O_timeout
);

    localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                    state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r;
    logic                      wb_en_r;
    logic                      set_carry_r;
    logic                      carry_r;
    logic                      reg_we_r;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_r;
    logic [DATA_WIDTH-1:0]     reg_data_r;
    logic                      timeout_r;
    logic                      stall_s;

    // Issue/complete FSM with watchdog; write port only moves on a real write so it holds otherwise.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rd_r        <= REG_ZERO;
            wb_en_r     <= 1'b0;
            set_carry_r <= 1'b0;
            carry_r     <= 1'b0;
            reg_we_r    <= 1'b0;
            reg_addr_r  <= REG_ZERO;
            reg_data_r  <= {DATA_WIDTH{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            reg_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (I_valid && I_multiCycle) begin
                        rd_r        <= I_rd;
                        wb_en_r     <= I_wbEnable;
                        set_carry_r <= I_setCarry;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_WAIT;
                    end else if (I_valid) begin
                        if (I_wbEnable && (I_rd != REG_ZERO)) begin
                            reg_we_r   <= 1'b1;
                            reg_addr_r <= I_rd;
                            reg_data_r <= I_dataResult;
                        end else begin
                            reg_we_r <= 1'b0;
                        end
                        if (I_setCarry) begin
                            carry_r <= I_Cout;
                        end else begin
                            carry_r <= carry_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A late result arriving on the timeout cycle still completes normally.
                    if (I_dataReady) begin
                        if (wb_en_r && (rd_r != REG_ZERO)) begin
                            reg_we_r   <= 1'b1;
                            reg_addr_r <= rd_r;
                            reg_data_r <= I_dataResult;
                        end else begin
                            reg_we_r <= 1'b0;
                        end
                        if (set_carry_r) begin
                            carry_r <= I_Cout;
                        end else begin
                            carry_r <= carry_r;
                        end
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall covers the issue cycle and every WAIT cycle that does not deliver the result.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = I_valid && I_multiCycle;
            ST_WAIT: stall_s = !I_dataReady;
            default: stall_s = 1'b0;
        endcase
    end

    assign O_stall   = stall_s;
    assign O_carry   = carry_r;
    assign O_regWe   = reg_we_r;
    assign O_regAddr = reg_addr_r;
    assign O_regData = reg_data_r;
    assign O_timeout = timeout_r;

endmodule
